// File: rtl/topk_pkg.sv
// ---------------------------------------------------------------------------
// topk_pkg
//
// Shared definitions for the top-K result drain:
//   - entry and result-set geometry (one entry = {index[15:0], data[7:0]})
//   - bit positions of the fields inside a 32-bit output word
//   - the sorter's initial score value for empty slots
//   - the drain state machine encoding
//   - a helper that assembles one output word from its fields
// ---------------------------------------------------------------------------
package topk_pkg;

    localparam int DATA_W    = 8;
    localparam int INDEX_W   = 16;
    localparam int ENTRY_W   = INDEX_W + DATA_W;
    localparam int N_RANKS   = 5;
    localparam int SET_W     = ENTRY_W * N_RANKS;

    // Output word layout: {rank[2:0], set_id[4:0], index[15:0], data[7:0]}
    localparam int OUT_W         = 32;
    localparam int RANK_W        = 3;
    localparam int SETID_W       = 5;
    localparam int OUT_ENTRY_LSB = 0;
    localparam int OUT_SETID_LSB = 24;
    localparam int OUT_RANK_LSB  = 29;

    // Score the sorter loads into empty slots; such entries are emitted as-is.
    localparam logic [DATA_W-1:0] DATA_INIT = 8'h80;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    function automatic logic [OUT_W-1:0] pack_word(
        input logic [RANK_W-1:0]  rank,
        input logic [SETID_W-1:0] set_id,
        input logic [ENTRY_W-1:0] entry
    );
        logic [OUT_W-1:0] word;
        word = '0;
        word[OUT_RANK_LSB  +: RANK_W]  = rank;
        word[OUT_SETID_LSB +: SETID_W] = set_id;
        word[OUT_ENTRY_LSB +: ENTRY_W] = entry;
        return word;
    endfunction

endpackage

// File: rtl/topk_result_drain_fifo.sv
// ---------------------------------------------------------------------------
// topk_set_fifo
//
// Small register FIFO holding whole result sets.
//
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset (storage -> 0)
//   clr              : synchronous empty (pointers and count only)
//   push, wdata      : write one set; ignored when full unless pop is also high
//   pop              : retire the head set; ignored when empty
//   head             : set at the read pointer (registered storage)
//   count            : number of sets held
//   full, empty      : occupancy flags
// ---------------------------------------------------------------------------
module topk_set_fifo #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO still accepts a push alongside a pop.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/topk_result_drain.sv
// ---------------------------------------------------------------------------
// topk_result_drain
//
// Captures each final top-5 result set from the sorter into a small set FIFO
// and serializes it as five 32-bit words over a valid/ready stream. The
// sorter is never stalled: when the FIFO is full and nothing leaves, the new
// set is dropped and the sticky overflow flag is raised.
//
// Ports:
//   sys_clk, sys_rst  : clock, asynchronous active-high reset
//   sorter_clr        : synchronous clear shared with the sorter
//   sorter_result     : five packed entries {index, data}, rank 0 in [23:0]
//   sorter_valid      : sorter_result valid this cycle
//   last_sort_i       : marks the final set of a sorting sequence
//   out_valid/ready   : output stream handshake
//   out_data          : {rank, set_id, index, data}
//   out_last          : high on the rank-4 word
//   set_done          : one-cycle pulse after the rank-4 word is accepted
//   overflow          : sticky, a set was dropped
// ---------------------------------------------------------------------------
module topk_result_drain
    import topk_pkg::*;
#(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16,
    parameter int N           = 5,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         sorter_clr,
    input  logic [255:0] sorter_result,
    input  logic         sorter_valid,
    input  logic         last_sort_i,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         set_done,
    output logic         overflow
);

    localparam int ENTRY_BITS = Index_Width + Data_Width;
    localparam int SET_BITS   = ENTRY_BITS * N;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(N - 1);

    drain_state_e         state_q, state_d;
    logic [RANK_W-1:0]    rank_cnt_q, rank_cnt_d;
    logic [SETID_W-1:0]   set_id_q, set_id_d;
    logic                 overflow_q, overflow_d;
    logic                 set_done_q, set_done_d;

    logic                 cap;
    logic                 xfer;
    logic                 final_xfer;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 drop;
    logic [SET_BITS-1:0]  fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_BITS-1:0] head_entry;
    logic                 unused_result_bits;

    // Only the five ranked entries are stored; the rest of the bus is spare.
    assign unused_result_bits = ^sorter_result[255:SET_BITS];

    assign cap        = sorter_valid & last_sort_i;
    assign out_valid  = (state_q == SEND);
    assign xfer       = out_valid & out_ready;
    assign final_xfer = xfer & (rank_cnt_q == LAST_RANK);

    // The clear wins over everything: a capture or a pop in the same cycle
    // as sorter_clr has no effect on the FIFO.
    assign fifo_pop  = final_xfer & ~sorter_clr;
    assign fifo_push = cap & ~sorter_clr & (~fifo_full | final_xfer);
    assign drop      = cap & ~sorter_clr & fifo_full & ~final_xfer;

    topk_set_fifo #(
        .WIDTH (SET_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_set_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (sorter_clr),
        .push    (fifo_push),
        .wdata   (sorter_result[SET_BITS-1:0]),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Select the head-set entry for the current rank. Both operands are
    // registers, so out_data has no path from any input.
    always_comb begin
        head_entry = '0;
        for (int r = 0; r < N; r++) begin
            if (rank_cnt_q == RANK_W'(r)) begin
                head_entry = fifo_head[r*ENTRY_BITS +: ENTRY_BITS];
            end
        end
    end

    // Words are held steady while stalled because rank_cnt and the FIFO
    // head only move on a transfer.
    assign out_data = out_valid ? pack_word(rank_cnt_q, set_id_q, head_entry) : '0;
    assign out_last = out_valid & (rank_cnt_q == LAST_RANK);
    assign set_done = set_done_q;
    assign overflow = overflow_q;

    // Next-state logic. On the final word of a set we stay in SEND when
    // another set remains (or is arriving this very cycle) so consecutive
    // sets stream without a bubble.
    always_comb begin
        state_d    = state_q;
        rank_cnt_d = rank_cnt_q;
        set_id_d   = set_id_q;
        overflow_d = overflow_q | drop;
        set_done_d = final_xfer;
        if (sorter_clr) begin
            state_d    = IDLE;
            rank_cnt_d = '0;
            set_id_d   = '0;
            overflow_d = 1'b0;
            set_done_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (final_xfer) begin
                        rank_cnt_d = '0;
                        set_id_d   = set_id_q + SETID_W'(1);
                        state_d    = ((fifo_count > CNT_W'(1)) || fifo_push) ? SEND : IDLE;
                    end else if (xfer) begin
                        rank_cnt_d = rank_cnt_q + RANK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            rank_cnt_q <= '0;
            set_id_q   <= '0;
            overflow_q <= 1'b0;
            set_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rank_cnt_q <= rank_cnt_d;
            set_id_q   <= set_id_d;
            overflow_q <= overflow_d;
            set_done_q <= set_done_d;
        end
    end

endmodule

// File: tb/tb_topk_result_drain.sv
// ---------------------------------------------------------------------------
// tb_topk_result_drain
//
// Scoreboard bench for topk_result_drain. A reference model tracks the set
// queue, the word position and the flags, and pushes the five expected words
// of every accepted set into expQ. A monitor compares the DUT against the
// model every cycle and against expQ on every accepted word.
// ---------------------------------------------------------------------------
module tb_topk_result_drain;

    localparam int DEPTH = 2;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         sorter_clr = 1'b0;
    logic [255:0] sorter_result = '0;
    logic         sorter_valid = 1'b0;
    logic         last_sort_i = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         set_done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [32:0] expQ[$];
    int          mSets = 0;
    int          mRank = 0;
    int          pushId = 0;
    bit          mSending = 1'b0;
    bit          mOverflow = 1'b0;
    bit          mSetDone = 1'b0;
    bit          mHs, mPopNow, mWasSending;
    int          mOldSets;

    // Every word the DUT handed over, in order
    logic [31:0] hsLog[$];

    topk_result_drain #(
        .Data_Width  (8),
        .Index_Width (16),
        .N           (5),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .sorter_clr    (sorter_clr),
        .sorter_result (sorter_result),
        .sorter_valid  (sorter_valid),
        .last_sort_i   (last_sort_i),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .set_done      (set_done),
        .overflow      (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: a queue of stored sets, a position within the head
    // set, and a sending flag that turns on one cycle after the queue was
    // seen non-empty and stays on while sets remain after a set finishes.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst || sorter_clr) begin
            expQ.delete();
            mSets     = 0;
            mRank     = 0;
            pushId    = 0;
            mSending  = 1'b0;
            mOverflow = mOverflow & ~(sys_rst | sorter_clr);
            mSetDone  = 1'b0;
        end else begin
            mHs         = mSending && out_ready;
            mPopNow     = mHs && (mRank == 4);
            mOldSets    = mSets;
            mWasSending = mSending;
            if (mHs) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                if (mPopNow) begin
                    mSets = mSets - 1;
                    mRank = 0;
                end else begin
                    mRank = mRank + 1;
                end
            end
            mSetDone = mPopNow;
            if (sorter_valid && last_sort_i) begin
                if (mOldSets == DEPTH && !mPopNow) begin
                    mOverflow = 1'b1;
                end else begin
                    mSets = mSets + 1;
                    for (int r = 0; r < 5; r++) begin
                        expQ.push_back({(r == 4), 3'(r), 5'(pushId % 32), sorter_result[r*24 +: 24]});
                    end
                    pushId = pushId + 1;
                end
            end
            mSending = mWasSending ? (!mPopNow || mSets > 0) : (mOldSets != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle: inputs are set now (just after an edge), held through
    // the next rising edge, and the task returns 1 time unit after that edge.
    task automatic applyStimulus(input bit vld, input bit lst, input bit rdy, input bit clr,
                                 input logic [255:0] res);
        sorter_valid  = vld;
        last_sort_i   = lst;
        out_ready     = rdy;
        sorter_clr    = clr;
        sorter_result = res;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic runMonitor();
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                checkOutput("out_valid", 32'(out_valid), 32'(mSending));
                checkOutput("overflow", 32'(overflow), 32'(mOverflow));
                checkOutput("set_done", 32'(set_done), 32'(mSetDone));
                if (out_valid && out_ready) begin
                    hsLog.push_back(out_data);
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got 0x%08h, expected no word at %0t", out_data, $time);
                    end else begin
                        checkOutput("out_data", out_data, expQ[0][31:0]);
                        checkOutput("out_last", 32'(out_last), 32'(expQ[0][32]));
                    end
                end
            end
        end
    endtask

    function automatic logic [255:0] randResult();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
        for (int r = 0; r < 5; r++) begin
            if ($urandom_range(0, 5) == 0) v[24*r +: 8] = 8'h80;
        end
        return v;
    endfunction

    function automatic logic [255:0] makeSet(input logic [15:0] i0, input logic [7:0] d0,
                                             input logic [15:0] i1, input logic [7:0] d1,
                                             input logic [15:0] i2, input logic [7:0] d2,
                                             input logic [15:0] i3, input logic [7:0] d3,
                                             input logic [15:0] i4, input logic [7:0] d4);
        logic [255:0] v;
        v = '0;
        v[119:0] = {i4, d4, i3, d3, i2, d2, i1, d1, i0, d0};
        return v;
    endfunction

    initial begin
        logic [255:0] knownA;
        logic [31:0]  expA[5];
        int           base;
        int           guard;
        bit           rv, rl, rr, rc;

        fork
            runMonitor();
        join_none

        knownA  = makeSet(16'd7, 8'h50, 16'd3, 8'h40, 16'd9, 8'h30, 16'd1, 8'h20, 16'd4, 8'h10);
        expA[0] = 32'h0000_0750;
        expA[1] = 32'h2000_0340;
        expA[2] = 32'h4000_0930;
        expA[3] = 32'h6000_0120;
        expA[4] = 32'h8000_0410;

        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_set_done", 32'(set_done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        sys_rst = 1'b0;

        // One known set with out_ready held high
        applyStimulus(1, 1, 1, 0, knownA);
        checkOutput("latency_edge_k", 32'(out_valid), 32'd0);
        base = hsLog.size();
        applyStimulus(0, 0, 1, 0, '0);
        checkOutput("latency_edge_k1", 32'(out_valid), 32'd1);
        repeat (7) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("set1_word_count", 32'(hsLog.size() - base), 32'd5);
        if (hsLog.size() - base == 5) begin
            for (int i = 0; i < 5; i++) checkOutput("set1_word", hsLog[base+i], expA[i]);
        end

        // Intermediate results are ignored
        base = hsLog.size();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 0, randResult());
            checkOutput("intermediate_valid", 32'(out_valid), 32'd0);
        end
        checkOutput("intermediate_words", 32'(hsLog.size() - base), 32'd0);

        // Overflow: three captures against a stalled output
        applyStimulus(0, 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, randResult());
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        base = hsLog.size();
        repeat (12) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("overflow_drain_words", 32'(hsLog.size() - base), 32'd10);
        if (hsLog.size() - base == 10) begin
            checkOutput("overflow_set_id0", 32'(hsLog[base][28:24]), 32'd0);
            checkOutput("overflow_set_id1", 32'(hsLog[base+5][28:24]), 32'd1);
        end
        applyStimulus(0, 0, 1, 1, '0);
        checkOutput("clr_overflow", 32'(overflow), 32'd0);

        // Capture while full on the cycle of the final handshake
        applyStimulus(1, 1, 0, 0, randResult());
        applyStimulus(1, 1, 0, 0, randResult());
        applyStimulus(0, 0, 0, 0, '0);
        base  = hsLog.size();
        guard = 0;
        while (!(mSending && mRank == 4) && guard < 20) begin
            applyStimulus(0, 0, 1, 0, '0);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL full_pop_wait: got timeout, expected rank 4 within 20 cycles");
        end
        applyStimulus(1, 1, 1, 0, randResult());
        repeat (20) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("full_pop_overflow", 32'(overflow), 32'd0);
        checkOutput("full_pop_words", 32'(hsLog.size() - base), 32'd15);

        // sorter_clr after rank 2 is accepted (with a discarded capture)
        applyStimulus(1, 1, 1, 0, randResult());
        guard = 0;
        while (!(mSending && mRank == 3) && guard < 20) begin
            applyStimulus(0, 0, 1, 0, '0);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL clr_wait: got timeout, expected rank 3 within 20 cycles");
        end
        applyStimulus(1, 1, 1, 1, randResult());
        checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_overflow2", 32'(overflow), 32'd0);
        repeat (3) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("clr_cap_dropped", 32'(out_valid), 32'd0);
        base = hsLog.size();
        applyStimulus(1, 1, 1, 0, makeSet(16'h1234, 8'h77, 16'h00AA, 8'h80, 16'h0001, 8'h01,
                                          16'h0002, 8'h02, 16'h0003, 8'h03));
        repeat (8) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("after_clr_words", 32'(hsLog.size() - base), 32'd5);
        if (hsLog.size() - base == 5) begin
            checkOutput("after_clr_first", hsLog[base], 32'h0012_3477);
            checkOutput("placeholder_word", hsLog[base+1], 32'h2000_AA80);
        end

        // Asynchronous reset in the middle of a set
        applyStimulus(1, 1, 1, 0, randResult());
        applyStimulus(0, 0, 1, 0, '0);
        applyStimulus(0, 0, 1, 0, '0);
        sys_rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_data", out_data, 32'd0);
        checkOutput("async_rst_last", 32'(out_last), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // 34 sets back to back: set_id wraps from 31 to 0
        base = hsLog.size();
        for (int s = 0; s < 34; s++) begin
            applyStimulus(1, 1, 1, 0, randResult());
            repeat (4) applyStimulus(0, 0, 1, 0, '0);
        end
        repeat (10) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("wrap_words", 32'(hsLog.size() - base), 32'd170);
        if (hsLog.size() - base == 170) begin
            checkOutput("wrap_set_id31", 32'(hsLog[base+5*31][28:24]), 32'd31);
            checkOutput("wrap_set_id0", 32'(hsLog[base+5*32][28:24]), 32'd0);
        end

        // Randomized traffic with back-pressure, drops and rare clears
        for (int c = 0; c < 1500; c++) begin
            rv = ($urandom_range(0, 9) < 4);
            rl = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 6);
            rc = ($urandom_range(0, 199) == 0);
            applyStimulus(rv, rl, rr, rc, randResult());
        end
        repeat (30) applyStimulus(0, 0, 1, 0, '0);
        checkOutput("final_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
